fifo_ctrl: RTL and testbench

Pointer and flag controller for a synchronous FIFO built around the team's register-file RAM stage. The RAM has a synchronous write and an asynchronous (combinational) read. This block sits directly upstream of the RAM: it accepts push/pop requests, drives the RAM's write address, read address and write enable, and reports full, empty and occupancy. A fifo top instantiates this block plus one RAM with matching ADDR_WIDTH and DATA_WIDTH; the FIFO's wdata and rdata pass straight through to the RAM.

---
 rtl/fifo_ctrl.sv | 82 ++++++++
 tb/tb_fifo_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and flag controller for a synchronous FIFO
// built on a register-file RAM (synchronous write, combinational read).
// The write/read addresses come straight from the pointer registers.
// full/empty are registered from the next occupancy, so there is no
// combinational path from push/pop to any flag or to count.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  we,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  // Occupancy value that means every RAM entry holds live data.
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  do_push, do_pop;

  // Qualify requests against the registered flags and compute next state.
  // A push while full is still accepted when a pop frees the head slot in
  // the same cycle; the pop side reads the old head before the edge.
  always_comb begin
    do_push     = push & (~full_q | pop);
    do_pop      = pop & ~empty_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    count_d     = count_q + (ADDR_WIDTH+1)'(do_push) - (ADDR_WIDTH+1)'(do_pop);
    full_d      = (count_d == DEPTH_CNT);
    empty_d     = (count_d == '0);
    overflow_d  = push & full_q & ~pop;
    underflow_d = pop & empty_q;
  end

  // State registers; reset discards all contents without touching the RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign waddr     = wptr_q;
  assign raddr     = rptr_q;
  assign we        = do_push;
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: wraps the controller with a behavioural register-file
// RAM and checks it against a queue-based FIFO reference model, plus a
// directed vector table and hand-written corner-case sequences.
module tb_fifo_ctrl;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          push, pop;
  logic [7:0]    wdata;
  logic [7:0]    rdata;
  logic [AW-1:0] waddr, raddr;
  logic          we, full, empty, overflow, underflow;
  logic [AW:0]   count;

  fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .waddr(waddr), .raddr(raddr), .we(we), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Register-file RAM: synchronous write, combinational read.
  logic [7:0] mem [DEPTH];
  always @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];

  // Reference model: queue contents plus total accepted push/pop counts.
  logic [7:0] mq[$];
  int  npush, npop;
  bit  m_ovf, m_unf;
  bit  cur_p, cur_q;
  logic [7:0] cur_wd;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    mq.delete();
    npush = 0; npop = 0; m_ovf = 0; m_unf = 0;
  endfunction

  // Drive inputs at posedge+1, check everything against the model at negedge.
  task automatic drive(input bit p, input bit q, input logic [7:0] wd);
    bit exp_we;
    push = p; pop = q; wdata = wd;
    cur_p = p; cur_q = q; cur_wd = wd;
    #4;
    exp_we = p && (mq.size() < DEPTH || q);
    chk("waddr", waddr, npush % DEPTH);
    chk("raddr", raddr, npop % DEPTH);
    chk("count", count, mq.size());
    chk("full", full, mq.size() == DEPTH);
    chk("empty", empty, mq.size() == 0);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
    chk("we", we, exp_we);
    if (q && mq.size() > 0) chk("rdata", rdata, mq[0]);
  endtask

  // Clock edge, then advance the model with the inputs that were applied.
  task automatic advance();
    bit acc_push, acc_pop;
    @(posedge clk);
    #1;
    acc_pop  = cur_q && mq.size() > 0;
    acc_push = cur_p && (mq.size() < DEPTH || cur_q);
    m_ovf    = cur_p && mq.size() == DEPTH && !cur_q;
    m_unf    = cur_q && mq.size() == 0;
    if (acc_pop)  begin void'(mq.pop_front()); npop++; end
    if (acc_push) begin mq.push_back(cur_wd); npush++; end
  endtask

  task automatic cycle(input bit p, input bit q, input logic [7:0] wd);
    drive(p, q, wd);
    advance();
  endtask

  task automatic do_reset();
    push = 0; pop = 0; wdata = 0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  typedef struct {
    bit         p;
    bit         q;
    logic [7:0] wd;
    bit         e_we;
    int         e_waddr;
    int         e_raddr;
    int         e_count;
    bit         e_empty;
    bit         e_unf;
    bit         chk_rd;
    logic [7:0] e_rd;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic push 0x11..0x13 then drain, with a trailing dropped pop.
    tbl[0] = '{1, 0, 8'h11, 1, 0, 0, 0, 1, 0, 0, 8'h00};
    tbl[1] = '{1, 0, 8'h12, 1, 1, 0, 1, 0, 0, 0, 8'h00};
    tbl[2] = '{1, 0, 8'h13, 1, 2, 0, 2, 0, 0, 0, 8'h00};
    tbl[3] = '{0, 1, 8'h00, 0, 3, 0, 3, 0, 0, 1, 8'h11};
    tbl[4] = '{0, 1, 8'h00, 0, 3, 1, 2, 0, 0, 1, 8'h12};
    tbl[5] = '{0, 1, 8'h00, 0, 3, 2, 1, 0, 0, 1, 8'h13};
    tbl[6] = '{0, 0, 8'h00, 0, 3, 3, 0, 1, 0, 0, 8'h00};
    tbl[7] = '{0, 1, 8'h00, 0, 3, 3, 0, 1, 0, 0, 8'h00};
    tbl[8] = '{0, 0, 8'h00, 0, 3, 3, 0, 1, 1, 0, 8'h00};
    tbl[9] = '{0, 0, 8'h00, 0, 3, 3, 0, 1, 0, 0, 8'h00};

    push = 0; pop = 0; wdata = 0;
    model_clear();
    reset = 1'b1;
    #2;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].p, tbl[i].q, tbl[i].wd);
      chk("tbl_we", we, tbl[i].e_we);
      chk("tbl_waddr", waddr, tbl[i].e_waddr);
      chk("tbl_raddr", raddr, tbl[i].e_raddr);
      chk("tbl_count", count, tbl[i].e_count);
      chk("tbl_empty", empty, tbl[i].e_empty);
      chk("tbl_unf", underflow, tbl[i].e_unf);
      if (tbl[i].chk_rd) chk("tbl_rdata", rdata, tbl[i].e_rd);
      advance();
    end

    // Fill to full, then a dropped 17th push.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, 8'(8'h20 + i));
    drive(1, 0, 8'hEE);
    chk("full_set", full, 1);
    chk("full_count", count, DEPTH);
    chk("ovf_we", we, 0);
    advance();
    drive(0, 0, 8'h00);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_wptr", waddr, 0);
    advance();
    drive(0, 0, 8'h00);
    chk("ovf_cleared", overflow, 0);
    advance();

    // Push and pop together while full.
    drive(1, 1, 8'hAA);
    chk("fullpp_rdata", rdata, 8'h20);
    chk("fullpp_we", we, 1);
    advance();
    drive(0, 0, 8'h00);
    chk("fullpp_full", full, 1);
    chk("fullpp_count", count, DEPTH);
    advance();
    for (int i = 0; i < DEPTH - 1; i++) cycle(0, 1, 8'h00);
    drive(0, 1, 8'h00);
    chk("fullpp_last", rdata, 8'hAA);
    advance();

    // Push and pop together while empty.
    do_reset();
    drive(1, 1, 8'h5C);
    chk("emptypp_we", we, 1);
    advance();
    drive(0, 0, 8'h00);
    chk("emptypp_unf", underflow, 1);
    chk("emptypp_count", count, 1);
    chk("emptypp_rptr", raddr, 0);
    advance();
    cycle(0, 1, 8'h00);

    // Streaming 40 entries with occupancy held between 1 and 3.
    do_reset();
    begin
      int pushed = 0;
      int guard  = 0;
      bit p, q;
      while ((pushed < 40 || mq.size() > 0) && guard < 1000) begin
        p = (pushed < 40) && (mq.size() < 3) && (mq.size() <= 1 || $urandom_range(3) != 0);
        q = (mq.size() > 1 && $urandom_range(1) == 1) || (pushed == 40 && mq.size() > 0);
        if (p) pushed++;
        cycle(p, q, 8'($urandom));
        guard++;
      end
      chk("stream_budget", guard < 1000, 1);
      chk("stream_wrap", npop, 40);
    end

    // Unconstrained random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int bias = (i / 100) % 2;
      bit p = ($urandom_range(3) < (bias ? 3 : 1));
      bit q = ($urandom_range(3) < (bias ? 1 : 3));
      cycle(p, q, 8'($urandom));
    end

    // Asynchronous reset in the middle of a cycle with 5 entries held.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'h40 + i));
    push = 0; pop = 0;
    #2;
    chk("pre_async_count", count, 5);
    reset = 1'b1;
    #1;
    chk("async_empty", empty, 1);
    chk("async_count", count, 0);
    chk("async_waddr", waddr, 0);
    chk("async_raddr", raddr, 0);
    reset = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    drive(1, 0, 8'h77);
    chk("post_async_waddr", waddr, 0);
    chk("post_async_we", we, 1);
    advance();
    drive(0, 1, 8'h00);
    chk("post_async_rdata", rdata, 8'h77);
    advance();
    cycle(0, 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
